mult_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 47 ++++
 rtl/mdu_step.sv | 37 +++
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states, default widths and two's-complement helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_e;

    typedef logic [MDU_WIDTH-1:0]   word_t;
    typedef logic [2*MDU_WIDTH-1:0] dword_t;

    // Divide ops have op[1] set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops (MULT, DIV) have op[0] clear.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic word_t neg_w(input word_t x);
        return ~x + word_t'(1);
    endfunction

    function automatic dword_t neg_dw(input dword_t x);
        return ~x + dword_t'(1);
    endfunction

    // Magnitude of x; 0x80000000 maps to itself and is then read as unsigned.
    function automatic word_t abs_w(input word_t x, input logic is_signed);
        return (is_signed && x[MDU_WIDTH-1]) ? neg_w(x) : x;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
// Multiply: conditional add into the upper half, then shift {carry, acc} right.
// Divide:   shift {rem, quot} left, trial-subtract divisor, set quotient bit.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               is_div_i,
    input  logic               mbit_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Compute both candidate updates and select by operation class.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (mbit_i ? operand_i : {WIDTH{1'b0}})};
        // Remainder after the left shift is WIDTH+1 bits wide, so the trial
        // subtract keeps the bit shifted out of the top.
        diff  = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};
        acc_o = acc_i;
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS32 multiply/divide unit (MULT, MULTU, DIV, DIVU) producing
// HI/LO. Operands are latched as magnitudes, WIDTH radix-2 steps run on
// unsigned values, and a final FIX cycle applies the sign correction.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod;

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i  (is_div_q),
        .mbit_i    (mplr_q[0]),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    // Next-state and datapath control: latch in IDLE, iterate in RUN,
    // sign-correct and publish HI/LO in FIX.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        raw_a_d  = raw_a_q;
        opnd_d   = opnd_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        sgn      = op_is_signed(op);
        abs_a    = abs_w(a, sgn);
        abs_b    = abs_w(b, sgn);
        prod     = (sa_q ^ sb_q) ? neg_dw(acc_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op_is_div(op);
                    sa_d     = sgn & a[WIDTH-1];
                    sb_d     = sgn & b[WIDTH-1];
                    raw_a_d  = a;
                    mplr_d   = abs_b;
                    cnt_d    = '0;
                    state_d  = RUN;
                    if (op_is_div(op)) begin
                        // Divide: divisor is the step operand, dividend
                        // starts in the quotient half and shifts up.
                        opnd_d = abs_b;
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = '0;
                    end
                end
            end
            RUN: begin
                acc_d  = step_acc;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    if (opnd_q == '0) begin
                        // Divide by zero: raw dividend in HI, all ones in LO.
                        hi_d = raw_a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                        hi_d = sa_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            raw_a_q  <= '0;
            opnd_q   <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            raw_a_q  <= raw_a_d;
            opnd_q   <= opnd_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal
// expectations plus randomized back-to-back traffic against a
// latency/arithmetic reference model.
module tb_mult_div_unit;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            2'b00: res = 64'(sx * sy);
            2'b01: res = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0) res = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (y == 0) res = {x, 32'hFFFFFFFF};
                else res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    // Model: an accepted start produces its result 33 edges later; starts
    // are accepted only when nothing is outstanding.
    int          m_rem   = 0;
    int          m_acc   = 0;
    logic        m_done  = 1'b0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [63:0] m_pend  = '0;
    int          dut_dones = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            if (m_rem > 0) m_acc--;
            m_rem  = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = ref_res(op, a, b);
                m_rem  = 33;
                m_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            if (done) dut_dones++;
        end
    end

    // Run one op from an idle cycle (#1 after a rising edge); leaves the
    // caller in the done cycle.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'd33);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int base;
        int cyc;

        // Pin the reference model against hand-computed values.
        chk("model multu max", ref_res(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
        chk("model mult -3*7", ref_res(2'b00, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
        chk("model div -7/2", ref_res(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model divu by 0", ref_res(2'b11, 32'd100, 32'd0), 64'h00000064_FFFFFFFF);
        chk("model div min/-1", ref_res(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        chk("model divu 100/7", ref_res(2'b11, 32'd100, 32'd7), 64'h00000002_0000000E);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        do_op("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult -3*7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu by 0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        do_op("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // Start while busy is ignored.
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy-start done seen", 64'(done), 64'd1);
        chk("busy-start hi", 64'(hi), 64'd2);
        chk("busy-start lo", 64'(lo), 64'd14);
        // Start in the done cycle is accepted.
        do_op("done-cycle multu", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

        // Asynchronous reset mid-operation.
        op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op("after abort multu", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

        // Randomized back-to-back traffic, including starts while busy.
        base = m_acc;
        cyc = 0;
        while (m_acc < base + 1000 && cyc < 60000) begin
            start = ($urandom_range(0, 3) != 0);
            op    = 2'($urandom);
            a     = rnd_operand();
            b     = rnd_operand();
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("random ops accepted", 64'(m_acc - base), 64'd1000);
        repeat (40) @(posedge clk);
        #1;
        chk("done pulses per start", 64'(dut_dones), 64'(m_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
